// File: rtl/anim_pkg.sv
// Shared encodings for the sprite animation scheduler.
package anim_pkg;

  // Speed-mode encodings as seen on speed_mode_in / speed_mode.
  localparam logic [1:0] SPD_STOP    = 2'b00;
  localparam logic [1:0] SPD_SLOW    = 2'b01;
  localparam logic [1:0] SPD_FAST    = 2'b10;
  localparam logic [1:0] SPD_DEFAULT = 2'b11;

  // Width of the free-running frame counter.
  localparam int FC_W = 7;

  // Scheduler state, visible on run_state for checkers.
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } run_state_t;

endpackage

// File: rtl/anim_scheduler_sel_debouncer.sv
// Two-flop synchronizer plus frame-sampled stability filter for a user selection.
// A new value must be seen unchanged on DEB_FRAMES consecutive frame strobes
// before it replaces the committed value. commit_now flags the strobe on which
// that happens so the caller can react in the same cycle; cand is the value
// being committed.
module sel_debouncer #(
  parameter int             W          = 2,
  parameter int             DEB_FRAMES = 3,
  parameter logic [W-1:0]   RESET_VAL  = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_start,
  input  logic [W-1:0] raw,
  output logic [W-1:0] sel,
  output logic [W-1:0] cand,
  output logic         commit_now
);

  localparam int             CNT_W   = $clog2(DEB_FRAMES + 1);
  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_FRAMES);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Stable-count step and same-cycle commit indication.
  always_comb begin
    cnt_inc    = cnt + CNT_W'(1);
    commit_now = frame_start && (sync2 == cand) && (sync2 != sel) && (cnt_inc == DEB_LIM);
  end

  // Synchronize the raw input and run the per-frame stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= RESET_VAL;
      sel   <= RESET_VAL;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (frame_start) begin
        if (sync2 != cand) begin
          cand <= sync2;
          cnt  <= CNT_W'(1);
        end else if (sync2 != sel) begin
          if (cnt_inc == DEB_LIM) begin
            sel <= cand;
            cnt <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/anim_scheduler.sv
// Frame-rate controller for the sprite animation path.
// Advances the animation frame index from per-frame strobes at a rate chosen
// by the debounced speed selection, supports stop and single-step, and raises
// a sound trigger on every animation-cycle wrap.
//
// Sound handshake: snd_req rises in the cycle after a wrapping advance and is
// held until snd_ack is sampled high on a clock edge; snd_req is low in the
// following cycle. snd_ack while snd_req is low is ignored, and a wrap while
// snd_req is already high does not queue another request.
module anim_scheduler
  import anim_pkg::*;
#(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_W     = 2,
  parameter int SLOW_DIV    = 4,
  parameter int FAST_DIV    = 2,
  parameter int DEFAULT_DIV = 64,
  parameter int DEB_FRAMES  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [1:0]         speed_mode_in,
  input  logic [1:0]         bg_sel_in,
  input  logic               step_in,
  input  logic               snd_ack,
  output logic [FRAME_W-1:0] frame_num,
  output logic [FC_W-1:0]    frame_counter,
  output logic [1:0]         speed_mode,
  output logic [1:0]         bg_sel,
  output logic               snd_req,
  output logic [1:0]         run_state
);

  localparam logic [6:0]         SLOW_LAST    = 7'(SLOW_DIV - 1);
  localparam logic [6:0]         FAST_LAST    = 7'(FAST_DIV - 1);
  localparam logic [6:0]         DEFAULT_LAST = 7'(DEFAULT_DIV - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME   = FRAME_W'(NUM_FRAMES - 1);

  run_state_t state;
  logic [6:0] div_cnt;
  logic [6:0] div_last;
  logic       step_s1, step_s2, step_d, step_pend, step_edge;
  logic       spd_commit;
  logic [1:0] spd_cand;
  logic [1:0] mode_eff;
  logic       advance, wrap;
  logic       bg_commit_unused;
  logic [1:0] bg_cand_unused;

  sel_debouncer #(.W(2), .DEB_FRAMES(DEB_FRAMES), .RESET_VAL(SPD_DEFAULT)) u_speed_deb (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .raw         (speed_mode_in),
    .sel         (speed_mode),
    .cand        (spd_cand),
    .commit_now  (spd_commit)
  );

  sel_debouncer #(.W(2), .DEB_FRAMES(DEB_FRAMES), .RESET_VAL(2'b00)) u_bg_deb (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .raw         (bg_sel_in),
    .sel         (bg_sel),
    .cand        (bg_cand_unused),
    .commit_now  (bg_commit_unused)
  );

  assign run_state = state;

  // Divider length, effective mode after this strobe, and advance/wrap decode.
  always_comb begin
    div_last = DEFAULT_LAST;
    case (speed_mode)
      SPD_SLOW: div_last = SLOW_LAST;
      SPD_FAST: div_last = FAST_LAST;
      default:  div_last = DEFAULT_LAST;
    endcase
    mode_eff  = spd_commit ? spd_cand : speed_mode;
    step_edge = step_s2 & ~step_d;
    // A strobe that commits a new speed never advances in RUN; STEP always does.
    advance   = frame_start &&
                (((state == ST_RUN) && !spd_commit && (div_cnt == div_last)) ||
                 (state == ST_STEP));
    wrap      = advance && (frame_num == LAST_FRAME);
  end

  // Step button synchronizer and edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_d  <= 1'b0;
    end else begin
      step_s1 <= step_in;
      step_s2 <= step_s1;
      step_d  <= step_s2;
    end
  end

  // Run/stop/step FSM with divider and pending-step latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      div_cnt   <= '0;
      step_pend <= 1'b0;
    end else begin
      if (step_edge && (state != ST_RUN)) step_pend <= 1'b1;
      case (state)
        ST_RUN: begin
          if (frame_start) begin
            if (spd_commit) begin
              div_cnt <= '0;
              if (spd_cand == SPD_STOP) state <= ST_STOP;
            end else if (div_cnt == div_last) begin
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + 7'd1;
            end
          end
        end
        ST_STOP: begin
          if (frame_start && spd_commit && (spd_cand != SPD_STOP)) begin
            state     <= ST_RUN;
            div_cnt   <= '0;
            step_pend <= 1'b0;
          end else if (step_pend) begin
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (frame_start) begin
            step_pend <= 1'b0;
            div_cnt   <= '0;
            state     <= (mode_eff != SPD_STOP) ? ST_RUN : ST_STOP;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Frame index and free-running frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_num     <= '0;
      frame_counter <= '0;
    end else begin
      if (frame_start) frame_counter <= frame_counter + FC_W'(1);
      if (advance)     frame_num     <= frame_num + FRAME_W'(1);
    end
  end

  // Sound trigger request, cleared by an acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snd_req <= 1'b0;
    end else if (snd_req && snd_ack) begin
      snd_req <= 1'b0;
    end else if (wrap) begin
      snd_req <= 1'b1;
    end
  end

endmodule
